// File: rtl/alsu_pkg.sv
// Shared types and helpers for the ALSU pipeline.
//   opcode_e   : operation codes carried on the opcode port
//   state_e    : top-level sequencing states
//   is_invalid : flags opcodes 6/7 and reductions on non-OR/XOR ops
package alsu_pkg;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_1 = 3'd6,
    INVALID_2 = 3'd7
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic is_invalid(input opcode_e opcode,
                                      input logic    red_op_A,
                                      input logic    red_op_B);
    logic bad_code;
    logic bad_red;
    bad_code = (opcode == INVALID_1) || (opcode == INVALID_2);
    bad_red  = (red_op_A || red_op_B) && (opcode != OR) && (opcode != XOR);
    return bad_code || bad_red;
  endfunction

endpackage

// File: rtl/alsu_seq_mult.sv
// Sequential signed multiplier, one shift-add step per clock.
//   clk, rst : clock, synchronous active-high reset (aborts a running product)
//   start    : load operands a/b; steps run on the following WIDTH edges
//   a, b     : signed operands
//   done     : high in the cycle before the last step's edge; product is
//              valid (combinationally) in that same cycle
//   product  : exact signed 2*WIDTH-bit result
module alsu_seq_mult #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    steps_left;
  logic             busy;
  logic             last_step;

  assign last_step = (steps_left == '0);
  assign addend    = mplier[0] ? mcand : '0;
  // The multiplier's MSB carries negative weight, so its partial product is
  // subtracted instead of added; this keeps the result exact for all signs,
  // including the most-negative operand squared.
  assign acc_next  = last_step ? (acc - addend) : (acc + addend);
  assign done      = busy && last_step;
  assign product   = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      steps_left <= '0;
    end else if (start) begin
      busy       <= 1'b1;
      acc        <= '0;
      mcand      <= {{WIDTH{a[WIDTH-1]}}, a};
      mplier     <= b;
      steps_left <= CW'(WIDTH - 1);
    end else if (busy) begin
      acc        <= acc_next;
      mcand      <= mcand << 1;
      mplier     <= mplier >> 1;
      steps_left <= steps_left - CW'(1);
      if (last_step) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// Handshaked ALSU: OR/XOR (with reductions), ADD, sequential MULT,
// SHIFT/ROTATE on the result register, bypass and sticky error LEDs.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake; ready only while IDLE
//   A, B, cin, serial_in, red_op_A/B, bypass_A/B, direction, opcode : operands
//   out, out_valid    : result register and its one-cycle write pulse
//   leds              : all-ones on error, then toggling until a valid op
//
// state | meaning
// IDLE  | accepting operands; captured non-MULT ops retire one edge later
// MUL   | multiplier stepping; source is back-pressured
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  input  logic                      cin,
  input  logic                      serial_in,
  input  logic                      red_op_A,
  input  logic                      red_op_B,
  input  logic                      bypass_A,
  input  logic                      bypass_B,
  input  logic                      direction,
  input  logic [2:0]                opcode,
  output logic signed [2*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic [LED_W-1:0]          leds
);

  localparam int OW      = 2 * WIDTH;
  localparam bit PRI_A   = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  state_e           state;
  logic             err;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [OW-1:0]    mul_product;

  logic             cap_valid;
  opcode_e          cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_cin;
  logic             cap_sin;
  logic             cap_ra;
  logic             cap_rb;
  logic             cap_ba;
  logic             cap_bb;
  logic             cap_dir;

  logic             cap_inv;
  logic             cap_byp;
  logic             cap_mul;
  logic             write_now;
  logic [OW-1:0]    a_ext;
  logic [OW-1:0]    b_ext;
  logic [WIDTH-1:0] red_opnd;
  logic [OW-1:0]    res;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  // Bypass and invalid ops retire through the normal one-edge path.
  assign mul_start = accept && (opcode_e'(opcode) == MULT) && !bypass_A && !bypass_B &&
                     !is_invalid(opcode_e'(opcode), red_op_A, red_op_B);

  alsu_seq_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (A),
    .b      (B),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_op  <= opcode_e'(opcode);
      cap_a   <= A;
      cap_b   <= B;
      cap_cin <= cin;
      cap_sin <= serial_in;
      cap_ra  <= red_op_A;
      cap_rb  <= red_op_B;
      cap_ba  <= bypass_A;
      cap_bb  <= bypass_B;
      cap_dir <= direction;
    end
  end

  assign cap_inv   = is_invalid(cap_op, cap_ra, cap_rb);
  assign cap_byp   = cap_ba || cap_bb;
  assign cap_mul   = (cap_op == MULT) && !cap_byp && !cap_inv;
  // A captured MULT is retired by the multiplier, not by this stage.
  assign write_now = cap_valid && !cap_mul;
  assign a_ext     = {{WIDTH{cap_a[WIDTH-1]}}, cap_a};
  assign b_ext     = {{WIDTH{cap_b[WIDTH-1]}}, cap_b};

  always_comb begin
    red_opnd = cap_ra ? cap_a : cap_b;
    if (cap_ra && cap_rb) begin
      red_opnd = PRI_A ? cap_a : cap_b;
    end
    res = '0;
    if (cap_ba && cap_bb) begin
      res = PRI_A ? a_ext : b_ext;
    end else if (cap_ba) begin
      res = a_ext;
    end else if (cap_bb) begin
      res = b_ext;
    end else if (!cap_inv) begin
      case (cap_op)
        OR:      res = (cap_ra || cap_rb) ? {{(OW-1){1'b0}}, |red_opnd} : (a_ext | b_ext);
        XOR:     res = (cap_ra || cap_rb) ? {{(OW-1){1'b0}}, ^red_opnd} : (a_ext ^ b_ext);
        ADD:     res = a_ext + b_ext + OW'(USE_CIN & cap_cin);
        SHIFT:   res = cap_dir ? {out[OW-2:0], cap_sin} : {cap_sin, out[OW-1:1]};
        ROTATE:  res = cap_dir ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
        default: res = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_valid <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      leds      <= '0;
    end else begin
      cap_valid <= accept;
      out_valid <= 1'b0;

      if (mul_start) begin
        state <= MUL;
      end else if (mul_done) begin
        state <= IDLE;
      end

      if (mul_done) begin
        out       <= mul_product;
        out_valid <= 1'b1;
      end else if (write_now) begin
        out       <= res;
        out_valid <= 1'b1;
      end

      // Bypassed ops neither clear the error nor stop the blinking.
      if (write_now && cap_inv) begin
        err  <= 1'b1;
        leds <= '1;
      end else if (mul_done || (write_now && !cap_byp)) begin
        err  <= 1'b0;
        leds <= '0;
      end else if (err) begin
        leds <= ~leds;
      end
    end
  end

endmodule

// File: tb/tb_alsu_pipe.sv
module tb_alsu_pipe;

  localparam int WIDTH = 3;
  localparam bit PRI_A = 1'b1;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       sin;
    logic       ra;
    logic       rb;
    logic       ba;
    logic       bb;
    logic       dir;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  A;
  logic [2:0]  B;
  logic        cin;
  logic        serial_in;
  logic        red_op_A;
  logic        red_op_B;
  logic        bypass_A;
  logic        bypass_B;
  logic        direction;
  logic [2:0]  opcode;
  logic [5:0]  out;
  logic        out_valid;
  logic [15:0] leds;

  int n_checks;
  int n_fail;
  int lat;
  int pulses;
  logic chk_en;
  txn_t t;

  alsu_pipe #(
    .WIDTH         (WIDTH),
    .INPUT_PRIORITY("A"),
    .FULL_ADDER    ("ON"),
    .LED_W         (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .cin      (cin),
    .serial_in(serial_in),
    .red_op_A (red_op_A),
    .red_op_B (red_op_B),
    .bypass_A (bypass_A),
    .bypass_B (bypass_B),
    .direction(direction),
    .opcode   (opcode),
    .out      (out),
    .out_valid(out_valid),
    .leds     (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic invalid_op(input txn_t x);
    return (x.op >= 3'd6) || ((x.ra || x.rb) && (x.op > 3'd1));
  endfunction

  function automatic logic [5:0] op_result(input txn_t x, input logic [5:0] cur);
    int sa;
    int sb;
    int c;
    logic [2:0] ro;
    sa = int'($signed(x.a));
    sb = int'($signed(x.b));
    c  = int'(cur);
    if (x.ba && x.bb) return 6'(PRI_A ? sa : sb);
    if (x.ba) return 6'(sa);
    if (x.bb) return 6'(sb);
    if (invalid_op(x)) return 6'd0;
    ro = (x.ra && x.rb) ? (PRI_A ? x.a : x.b) : (x.ra ? x.a : x.b);
    case (x.op)
      3'd0:    return (x.ra || x.rb) ? ((ro != 3'd0) ? 6'd1 : 6'd0) : 6'(sa | sb);
      3'd1:    return (x.ra || x.rb) ? 6'($countones(ro) % 2) : 6'(sa ^ sb);
      3'd2:    return 6'(sa + sb + int'(x.cin));
      3'd4:    return x.dir ? 6'(c * 2 + int'(x.sin)) : 6'(c / 2 + 32 * int'(x.sin));
      3'd5:    return x.dir ? 6'(c * 2 + c / 32) : 6'(c / 2 + 32 * (c % 2));
      default: return 6'd0;
    endcase
  endfunction

  logic [5:0]  m_out;
  logic        m_ov;
  logic [15:0] m_leds;
  logic        m_err;
  int          m_busy;
  logic [5:0]  m_prod;
  logic        pend_v;
  txn_t        pend;
  txn_t        cur_t;
  logic        m_acc;
  logic        ev_set;
  logic        ev_clr;

  always @(posedge clk) begin
    m_acc = in_valid && (m_busy == 0);
    cur_t = '{op: opcode, a: A, b: B, cin: cin, sin: serial_in, ra: red_op_A,
              rb: red_op_B, ba: bypass_A, bb: bypass_B, dir: direction};
    if (rst) begin
      m_out = 6'd0; m_ov = 1'b0; m_leds = 16'd0; m_err = 1'b0;
      m_busy = 0; pend_v = 1'b0;
    end else begin
      ev_set = 1'b0;
      ev_clr = 1'b0;
      m_ov   = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_out = m_prod; m_ov = 1'b1; ev_clr = 1'b1;
        end
      end
      if (pend_v) begin
        if (invalid_op(pend)) ev_set = 1'b1;
        if (pend.ba || pend.bb || invalid_op(pend) || pend.op != 3'd3) begin
          m_out = op_result(pend, m_out);
          m_ov  = 1'b1;
          if (!(pend.ba || pend.bb) && !invalid_op(pend)) ev_clr = 1'b1;
        end
      end
      if (ev_set) begin
        m_err = 1'b1; m_leds = 16'hFFFF;
      end else if (ev_clr) begin
        m_err = 1'b0; m_leds = 16'h0000;
      end else if (m_err) begin
        m_leds = ~m_leds;
      end
      pend_v = m_acc;
      if (m_acc) begin
        pend = cur_t;
        if (cur_t.op == 3'd3 && !cur_t.ba && !cur_t.bb && !invalid_op(cur_t)) begin
          m_busy = WIDTH;
          m_prod = 6'(int'($signed(cur_t.a)) * int'($signed(cur_t.b)));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("out", 32'(out), 32'(m_out));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("leds", 32'(leds), 32'(m_leds));
      check("in_ready", 32'(in_ready), 32'(m_busy == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic txn_t mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    txn_t x;
    x = '0;
    x.op = op; x.a = a; x.b = b;
    return x;
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; serial_in = 1'b0;
    red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
    direction = 1'b0; opcode = '0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input txn_t x);
    int guard;
    guard = 0;
    opcode = x.op; A = x.a; B = x.b; cin = x.cin; serial_in = x.sin;
    red_op_A = x.ra; red_op_B = x.rb; bypass_A = x.ba; bypass_B = x.bb;
    direction = x.dir; in_valid = 1'b1;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("send_accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Returns #1 after the edge that writes the result; lat counts edges.
  task automatic wait_result(output int l);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!out_valid && l < 40);
    check("result_seen", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    m_busy   = 0;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    t = mk(3'd2, 3'd3, 3'd3); t.cin = 1'b1;
    send(t); wait_result(lat);
    check("add_latency", 32'(lat), 32'd1);
    check("add_out", 32'(out), 32'b000111);
    check("model_add", 32'(m_out), 32'd7);
    @(negedge clk);

    send(mk(3'd3, 3'b100, 3'b100)); wait_result(lat);
    check("mul_latency", 32'(lat), 32'd3);
    check("mul_neg4_sq", 32'(out), 32'b010000);
    @(negedge clk);
    send(mk(3'd3, 3'b101, 3'b011)); wait_result(lat);
    check("mul_m3_x_3", 32'(out), 32'b110111);
    check("model_mul", 32'(m_out), 32'b110111);
    @(negedge clk);

    send(mk(3'd6, 3'd1, 3'd2)); wait_result(lat);
    check("inv_out", 32'(out), 32'd0);
    check("inv_leds_0", 32'(leds), 32'hFFFF);
    @(posedge clk); #1;
    check("inv_leds_1", 32'(leds), 32'h0000);
    @(posedge clk); #1;
    check("inv_leds_2", 32'(leds), 32'hFFFF);
    @(negedge clk);
    send(mk(3'd0, 3'd1, 3'd2)); wait_result(lat);
    check("or_out", 32'(out), 32'd3);
    check("or_clears_leds", 32'(leds), 32'd0);
    @(negedge clk);

    t = mk(3'd2, 3'd3, 3'd3); t.cin = 1'b1;
    send(t); wait_result(lat);
    @(negedge clk);
    t = mk(3'd4, 3'd0, 3'd0); t.dir = 1'b1; t.sin = 1'b1;
    send(t); wait_result(lat);
    check("shift_left", 32'(out), 32'b001111);
    @(negedge clk);
    t = mk(3'd5, 3'd0, 3'd0); t.dir = 1'b0;
    send(t); wait_result(lat);
    check("rotate_right", 32'(out), 32'b100111);
    check("model_rotate", 32'(m_out), 32'b100111);
    @(negedge clk);

    t = mk(3'd0, 3'b110, 3'b001); t.ba = 1'b1; t.bb = 1'b1;
    send(t); wait_result(lat);
    check("bypass_both", 32'(out), 32'b111110);
    @(negedge clk);
    t = mk(3'd2, 3'd1, 3'd1); t.ra = 1'b1;
    send(t); wait_result(lat);
    check("red_add_out", 32'(out), 32'd0);
    check("red_add_leds", 32'(leds), 32'hFFFF);
    @(posedge clk); #1;
    check("red_add_blink", 32'(leds), 32'h0000);
    @(negedge clk);
    t = mk(3'd2, 3'd3, 3'd0); t.ba = 1'b1;
    send(t); wait_result(lat);
    check("bypass_a_out", 32'(out), 32'd3);
    @(negedge clk);

    // Reset lands in the second cycle of a MULT; product 9 must never show.
    send(mk(3'd3, 3'd3, 3'd3));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out", 32'(out), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_leds", 32'(leds), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("abort_no_result", 32'(pulses), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      t.op  = 3'($urandom_range(0, 7));
      t.a   = 3'($urandom);
      t.b   = 3'($urandom);
      t.cin = 1'($urandom);
      t.sin = 1'($urandom);
      t.dir = 1'($urandom);
      t.ra  = ($urandom_range(0, 5) == 0);
      t.rb  = ($urandom_range(0, 5) == 0);
      t.ba  = ($urandom_range(0, 7) == 0);
      t.bb  = ($urandom_range(0, 7) == 0);
      send(t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
